// File: rtl/fifo_rv.sv
// Single-clock FWFT FIFO with valid/ready on both sides, any depth >= 2,
// fill level, almost-full/almost-empty decodes, synchronous flush and a high watermark.
module fifo_rv #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_TH  = DEPTH - 1,
    parameter int unsigned AEMPTY_TH = 1,
    localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             flush,
    output logic [LW-1:0]    level,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    max_level,
    input  logic             wm_clr
);

    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    max_level_q, max_level_d;
    logic             wr_fire, rd_fire;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign s_ready      = (level_q != DEPTH_L) && !flush;
    assign m_valid      = (level_q != '0) && !flush;
    assign wr_fire      = s_valid && s_ready;
    assign rd_fire      = m_valid && m_ready;
    assign m_data       = mem[rd_ptr_q];
    assign level        = level_q;
    assign max_level    = max_level_q;
    assign almost_full  = (level_q >= AFULL_L);
    assign almost_empty = (level_q <= AEMPTY_L);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        max_level_d = max_level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_fire, rd_fire})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
        // Flush forces level_d to 0, so flush+wm_clr clears the watermark.
        if (wm_clr) begin
            max_level_d = level_d;
        end else if (level_d > max_level_q) begin
            max_level_d = level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            max_level_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= s_data;
    end

endmodule

// File: tb/tb_fifo_rv.sv
// Bench for fifo_rv: three depths (4, 5, 3) share one stimulus stream and are
// compared every cycle against queue-based reference models, plus directed checks.
module tb_fifo_rv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       m_ready = 1'b0;
    logic       flush = 1'b0;
    logic       wm_clr = 1'b0;

    logic       sr4, mv4, af4, ae4;
    logic [7:0] md4;
    logic [2:0] lv4, mx4;
    logic       sr5, mv5, af5, ae5;
    logic [7:0] md5;
    logic [2:0] lv5, mx5;
    logic       sr3, mv3, af3, ae3;
    logic [7:0] md3;
    logic [1:0] lv3, mx3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q4[$];
    logic [7:0] q5[$];
    logic [7:0] q3[$];
    int m4 = 0, m5 = 0, m3 = 0;

    always #5 clk = ~clk;

    fifo_rv #(.WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr4), .s_data(s_data),
        .m_valid(mv4), .m_ready(m_ready), .m_data(md4), .flush(flush), .level(lv4),
        .almost_full(af4), .almost_empty(ae4), .max_level(mx4), .wm_clr(wm_clr)
    );

    fifo_rv #(.WIDTH(8), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) u_d5 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr5), .s_data(s_data),
        .m_valid(mv5), .m_ready(m_ready), .m_data(md5), .flush(flush), .level(lv5),
        .almost_full(af5), .almost_empty(ae5), .max_level(mx5), .wm_clr(wm_clr)
    );

    fifo_rv #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sr3), .s_data(s_data),
        .m_valid(mv3), .m_ready(m_ready), .m_data(md3), .flush(flush), .level(lv3),
        .almost_full(af3), .almost_empty(ae3), .max_level(mx3), .wm_clr(wm_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input int depth, input int af, input int ae,
                            input logic [7:0] lvl, input logic [7:0] mx, input logic [7:0] md,
                            input logic mv, input logic sr, input logic afl, input logic ael,
                            input int sz, input logic [7:0] head, input int mxm);
        check({nm, ".level"}, lvl, sz);
        check({nm, ".m_valid"}, mv, (sz > 0) && !flush);
        check({nm, ".s_ready"}, sr, (sz < depth) && !flush);
        check({nm, ".almost_full"}, afl, sz >= af);
        check({nm, ".almost_empty"}, ael, sz <= ae);
        check({nm, ".max_level"}, mx, mxm);
        if (sz > 0 && !flush) check({nm, ".m_data"}, md, head);
    endtask

    task automatic chk_rst(input string nm, input logic [7:0] lvl, input logic [7:0] mx,
                           input logic mv, input logic sr, input logic afl, input logic ael);
        check({nm, ".rst_level"}, lvl, 0);
        check({nm, ".rst_max"}, mx, 0);
        check({nm, ".rst_m_valid"}, mv, 0);
        check({nm, ".rst_s_ready"}, sr, 1);
        check({nm, ".rst_afull"}, afl, 0);
        check({nm, ".rst_aempty"}, ael, 1);
    endtask

    task automatic chk_rst_all(input string when);
        chk_rst({"d4", when}, 8'(lv4), 8'(mx4), mv4, sr4, af4, ae4);
        chk_rst({"d5", when}, 8'(lv5), 8'(mx5), mv5, sr5, af5, ae5);
        chk_rst({"d3", when}, 8'(lv3), 8'(mx3), mv3, sr3, af3, ae3);
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr,
                       input logic fl, input logic wc);
        logic w4, r4, w5, r5, w3, r3;
        @(negedge clk);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl; wm_clr = wc;
        #1;
        chk_inst("d4", 4, 3, 1, 8'(lv4), 8'(mx4), md4, mv4, sr4, af4, ae4,
                 q4.size(), (q4.size() > 0) ? q4[0] : 8'h00, m4);
        chk_inst("d5", 5, 4, 1, 8'(lv5), 8'(mx5), md5, mv5, sr5, af5, ae5,
                 q5.size(), (q5.size() > 0) ? q5[0] : 8'h00, m5);
        chk_inst("d3", 3, 2, 1, 8'(lv3), 8'(mx3), md3, mv3, sr3, af3, ae3,
                 q3.size(), (q3.size() > 0) ? q3[0] : 8'h00, m3);
        w4 = sv && q4.size() < 4 && !fl;  r4 = mr && q4.size() > 0 && !fl;
        w5 = sv && q5.size() < 5 && !fl;  r5 = mr && q5.size() > 0 && !fl;
        w3 = sv && q3.size() < 3 && !fl;  r3 = mr && q3.size() > 0 && !fl;
        @(posedge clk);
        if (fl) q4.delete();
        else begin
            if (r4) void'(q4.pop_front());
            if (w4) q4.push_back(sd);
        end
        if (fl) q5.delete();
        else begin
            if (r5) void'(q5.pop_front());
            if (w5) q5.push_back(sd);
        end
        if (fl) q3.delete();
        else begin
            if (r3) void'(q3.pop_front());
            if (w3) q3.push_back(sd);
        end
        m4 = wc ? q4.size() : ((q4.size() > m4) ? q4.size() : m4);
        m5 = wc ? q5.size() : ((q5.size() > m5) ? q5.size() : m5);
        m3 = wc ? q3.size() : ((q3.size() > m3) ? q3.size() : m3);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; wm_clr = 1'b0;
        #1;
        chk_rst_all("_during");
        q4.delete(); q5.delete(); q3.delete();
        m4 = 0; m5 = 0; m3 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_rst_all("_after");
    endtask

    initial begin
        do_reset();

        // Random traffic, then reset mid-stream.
        for (int i = 0; i < 10; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        do_reset();

        // Fill DEPTH=5 with A0..A4.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 2) check("d5.fill_afull_l3", af5, 0);
            if (i == 3) check("d5.fill_afull_l4", af5, 1);
        end
        check("d5.fill_level", lv5, 5);
        check("d5.fill_s_ready", sr5, 0);
        check("d5.fill_max", mx5, 5);

        // Drain and check order.
        for (int i = 0; i < 5; i++) begin
            check("d5.drain_data", md5, 8'hA0 + 8'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("d5.drain_aempty", ae5, (4 - i) <= 1);
        end
        check("d5.drain_level", lv5, 0);

        // Full plus concurrent read.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
        check("d5.fullrd_level", lv5, 4);
        check("d5.fullrd_s_ready", sr5, 1);
        check("d5.fullrd_head", md5, 8'hC1);
        cyc(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        check("d5.fullwr_level", lv5, 5);

        // Flush at level 3 with both handshakes requested.
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("d5.preflush_level", lv5, 3);
        cyc(1'b1, 8'hE0, 1'b1, 1'b1, 1'b0);
        check("d5.flush_level", lv5, 0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check("d5.postflush_data", md5, 8'h55);
        check("d5.postflush_m_valid", mv5, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Watermark restart.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("d5.wm_before_clr", mx5, 5);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("d5.wm_clr", mx5, 1);
        cyc(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        check("d5.wm_refill", mx5, 2);

        // Flush and watermark clear together.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("d5.flush_wmclr", mx5, 0);

        // Random stream, exercises wrap on DEPTH=3 and 5.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
            check("d3.level_bound", lv3 <= 2'd3, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
